// File: rtl/i2s_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : i2s_tx_fifo
// Brief   : Multi-lane I2S / left-justified audio transmitter fed by a
//           valid/ready sample FIFO, with underrun flag and mute.
// Rev     : 1.0  initial release
// ============================================================================
module i2s_tx_fifo #(
  parameter int SAMPLE_W   = 24,
  parameter int SLOT_W     = 32,
  parameter int LANES      = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            sclk,
  input  logic                            aclr,
  input  logic [LANES*2*SAMPLE_W-1:0]     s_data,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic                            fmt,
  input  logic                            mute,
  input  logic                            underrun_clr,
  output logic                            lrck,
  output logic [LANES-1:0]                dout,
  output logic                            underrun,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int c_FRAME  = 2 * SLOT_W;
  localparam int c_CNT_W  = $clog2(c_FRAME);
  localparam int c_AW     = $clog2(FIFO_DEPTH);
  localparam int c_WORD_W = LANES * 2 * SAMPLE_W;
  localparam int c_LAST_I = c_FRAME - 1;

  localparam logic [c_CNT_W-1:0] c_LAST = c_LAST_I[c_CNT_W-1:0];
  localparam logic [c_CNT_W-1:0] c_HALF = SLOT_W[c_CNT_W-1:0];
  localparam logic [c_CNT_W-1:0] c_ONE  = {{(c_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [c_AW:0]      c_FULL = FIFO_DEPTH[c_AW:0];
  localparam logic [c_AW:0]      c_PTR_ONE = {{c_AW{1'b0}}, 1'b1};

  // Frame counter and word select
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic               w_load;
  logic               r_lrck;

  always_comb begin
    w_load    = (r_cnt == c_LAST);
    w_cnt_nxt = w_load ? '0 : (r_cnt + c_ONE);
  end

  always_ff @(negedge sclk or posedge aclr) begin
    if (aclr) begin
      r_cnt  <= '0;
      r_lrck <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_lrck <= (w_cnt_nxt >= c_HALF);
    end
  end

  assign lrck = r_lrck;

  // Sample FIFO: pointers carry one extra wrap bit so full/empty are distinct
  logic [c_WORD_W-1:0] r_mem [FIFO_DEPTH];
  logic [c_AW:0]       r_wptr;
  logic [c_AW:0]       r_rptr;
  logic [c_AW:0]       w_level;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic [c_WORD_W-1:0] w_frame;

  always_comb begin
    w_level = r_wptr - r_rptr;
    w_full  = (w_level == c_FULL);
    w_empty = (w_level == '0);
    w_push  = s_valid && !w_full;
    // Emptiness is judged on registered state, so a same-edge push is not seen
    w_pop   = w_load && !w_empty;
    w_frame = (w_pop && !mute) ? r_mem[r_rptr[c_AW-1:0]] : '0;
  end

  always_ff @(negedge sclk) begin
    if (w_push) begin
      r_mem[r_wptr[c_AW-1:0]] <= s_data;
    end
  end

  always_ff @(negedge sclk or posedge aclr) begin
    if (aclr) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_PTR_ONE;
      end
    end
  end

  assign s_ready    = !w_full;
  assign fifo_level = w_level;

  // Sticky underrun; a new underrun beats a simultaneous clear
  logic r_underrun;

  always_ff @(negedge sclk or posedge aclr) begin
    if (aclr) begin
      r_underrun <= 1'b0;
    end else if (w_load && w_empty) begin
      r_underrun <= 1'b1;
    end else if (underrun_clr) begin
      r_underrun <= 1'b0;
    end
  end

  assign underrun = r_underrun;

  // Per-lane serialiser: r_bit_lj is the left-justified stream, r_bit_i2s
  // is the same stream one sclk later.
  generate
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic [SLOT_W-1:0]   w_slot_l;
      logic [SLOT_W-1:0]   w_slot_r;
      logic [c_FRAME-1:0]  w_load_vec;
      logic [c_FRAME-1:0]  r_shift;
      logic                r_bit_lj;
      logic                r_bit_i2s;

      always_comb begin
        w_slot_l = '0;
        w_slot_r = '0;
        w_slot_l[SLOT_W-1 -: SAMPLE_W] = w_frame[k*2*SAMPLE_W+SAMPLE_W +: SAMPLE_W];
        w_slot_r[SLOT_W-1 -: SAMPLE_W] = w_frame[k*2*SAMPLE_W +: SAMPLE_W];
        w_load_vec = {w_slot_l, w_slot_r};
      end

      always_ff @(negedge sclk or posedge aclr) begin
        if (aclr) begin
          r_shift   <= '0;
          r_bit_lj  <= 1'b0;
          r_bit_i2s <= 1'b0;
        end else begin
          if (w_load) begin
            r_bit_lj <= w_load_vec[c_FRAME-1];
            r_shift  <= {w_load_vec[c_FRAME-2:0], 1'b0};
          end else begin
            r_bit_lj <= r_shift[c_FRAME-1];
            r_shift  <= {r_shift[c_FRAME-2:0], 1'b0};
          end
          r_bit_i2s <= r_bit_lj;
        end
      end

      assign dout[k] = fmt ? r_bit_lj : r_bit_i2s;
    end
  endgenerate

endmodule
`default_nettype wire
